// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, NOP encoding and buffer entry type for the fetch unit
package fetch_pkg;
    localparam int XLEN_DEF       = 32;
    localparam int IMEM_DEPTH_DEF = 64;
    localparam int PC_MAX         = 64;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    typedef struct packed {
        logic [PC_MAX-1:0] pc;
        logic [31:0]       inst;
    } buf_entry_t;
endpackage

// File: rtl/fetch_imem.sv
// fetch_imem: synchronous-read instruction ROM, one cycle latency, image holds word k at index k
module fetch_imem #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic [AW-1:0] addr_i,
    output logic [31:0]   data_o
);
    logic [31:0] rom [DEPTH];
    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        assign rom[i] = 32'(i);
    end
    always_ff @(posedge clk_i)
        data_o <= rom[addr_i];
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch with redirect and output buffer; FETCH_FAULT_EN enables address faults
module fetch_unit import fetch_pkg::*; #(
    parameter int               XLEN       = XLEN_DEF,
    parameter int               IMEM_DEPTH = IMEM_DEPTH_DEF,
    parameter int               BUF_DEPTH  = 2,
    parameter logic [XLEN-1:0]  RESET_PC   = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            inst_valid_o,
    input  logic            inst_ready_i,
    output logic [31:0]     inst_o,
    output logic [XLEN-1:0] pc_o,
    output logic            fault_o
);
    localparam int AW = $clog2(IMEM_DEPTH);
    localparam int BW = $clog2(BUF_DEPTH);
    logic [XLEN-1:0] pc_q, rd_pc_q, fetch_pc, target, start_pc;
    logic [31:0]     rd_data;
    logic            rd_pend_q, fault_q, bad_addr, room, issue, pop;
    logic [BW+1:0]   occ;
    logic [BW-1:0]   head_q, tail_q;
    logic [BW:0]     count_q;
    buf_entry_t      buf_q [BUF_DEPTH];
`ifdef FETCH_FAULT_EN
    assign start_pc = RESET_PC;
    assign target   = redirect_pc_i;
    assign bad_addr = (|fetch_pc[1:0]) || ((fetch_pc >> 2) >= XLEN'(IMEM_DEPTH));
`else
    assign start_pc = RESET_PC & ~XLEN'(3);
    assign target   = redirect_pc_i & ~XLEN'(3);
    assign bad_addr = 1'b0;
`endif
    // A redirect reads its target in the same cycle so the target is valid two cycles later
    assign fetch_pc     = redirect_valid_i ? target : pc_q;
    assign inst_valid_o = count_q != '0;
    assign pop          = inst_valid_o && inst_ready_i;
    assign occ          = (BW+2)'(count_q) + (BW+2)'(rd_pend_q) - (BW+2)'(pop);
    assign room         = occ < (BW+2)'(BUF_DEPTH);
    assign issue        = !bad_addr && (redirect_valid_i || (!fault_q && room));
    assign inst_o       = inst_valid_o ? buf_q[head_q].inst : '0;
    assign pc_o         = inst_valid_o ? XLEN'(buf_q[head_q].pc) : '0;
    assign fault_o      = fault_q;
    fetch_imem #(.DEPTH(IMEM_DEPTH)) u_imem (
        .clk_i  (clk_i),
        .addr_i (fetch_pc[AW+1:2]),
        .data_o (rd_data)
    );
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q      <= start_pc;
            rd_pc_q   <= '0;
            rd_pend_q <= 1'b0;
            fault_q   <= 1'b0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else begin
            rd_pend_q <= issue;
            fault_q   <= redirect_valid_i ? bad_addr : fault_q | (bad_addr && room);
            if (issue) begin
                pc_q    <= fetch_pc + XLEN'(4);
                rd_pc_q <= fetch_pc;
            end else if (redirect_valid_i) begin
                pc_q <= target;
            end
            if (redirect_valid_i) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                if (rd_pend_q)
                    tail_q <= tail_q + 1'b1;
                if (pop)
                    head_q <= head_q + 1'b1;
                count_q <= count_q + (BW+1)'(rd_pend_q) - (BW+1)'(pop);
            end
        end
    end
    always_ff @(posedge clk_i)
        if (rd_pend_q && !redirect_valid_i)
            buf_q[tail_q] <= '{pc: PC_MAX'(rd_pc_q), inst: rd_data};
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit with ROM word k = k
module tb_fetch_unit;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        redirect_valid_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        inst_ready_i = 1'b1;
    logic        inst_valid_o, fault_o;
    logic [31:0] inst_o, pc_o;
    int total = 0;
    int bad = 0;

    always #5 clk_i = ~clk_i;

    fetch_unit dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .inst_valid_o     (inst_valid_o),
        .inst_ready_i     (inst_ready_i),
        .inst_o           (inst_o),
        .pc_o             (pc_o),
        .fault_o          (fault_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic exp_head(input string tag, input logic [31:0] pc, input logic [31:0] inst);
        chk({tag, "_valid"}, 64'(inst_valid_o), 64'd1);
        chk({tag, "_pc"}, 64'(pc_o), 64'(pc));
        chk({tag, "_inst"}, 64'(inst_o), 64'(inst));
    endtask

    task automatic exp_idle(input string tag);
        chk({tag, "_valid"}, 64'(inst_valid_o), 64'd0);
        chk({tag, "_pc"}, 64'(pc_o), 64'd0);
        chk({tag, "_inst"}, 64'(inst_o), 64'd0);
    endtask

    task automatic redirect(input logic [31:0] pc);
        redirect_valid_i = 1'b1;
        redirect_pc_i    = pc;
        tick();
        redirect_valid_i = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        exp_idle("reset");
        chk("reset_fault", 64'(fault_o), 64'd0);
        rst_i = 1'b0;
        tick();
        exp_idle("latency1");
        tick();
        exp_head("first", 32'h0, 32'd0);
        for (int k = 1; k < 8; k++) begin
            tick();
            exp_head("stream", 32'(4 * k), 32'(k));
        end
        rst_i = 1'b1;
        #1;
        exp_idle("async_rst");
        chk("async_rst_fault", 64'(fault_o), 64'd0);
        inst_ready_i = 1'b0;
        tick();
        rst_i = 1'b0;
        tick();
        exp_idle("restart_lat");
        tick();
        exp_head("restart", 32'h0, 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            exp_head("stall", 32'h0, 32'd0);
        end
        inst_ready_i = 1'b1;
        for (int k = 1; k < 5; k++) begin
            tick();
            exp_head("resume", 32'(4 * k), 32'(k));
        end
        redirect(32'h40);
        exp_idle("redir_bubble");
        tick();
        exp_head("redir", 32'h40, 32'd16);
        tick();
        exp_head("redir_next", 32'h44, 32'd17);
`ifdef FETCH_FAULT_EN
        redirect(32'h42);
        chk("mis_fault", 64'(fault_o), 64'd1);
        exp_idle("mis_idle");
        tick();
        chk("mis_fault_hold", 64'(fault_o), 64'd1);
        exp_idle("mis_idle_hold");
        redirect(32'h8);
        chk("clr_fault", 64'(fault_o), 64'd0);
        exp_idle("clr_bubble");
        tick();
        exp_head("clr", 32'h8, 32'd2);
        chk("clr_fault_hold", 64'(fault_o), 64'd0);
        redirect(32'hF8);
        exp_idle("end_bubble");
        tick();
        exp_head("end_f8", 32'hF8, 32'd62);
        chk("end_f8_fault", 64'(fault_o), 64'd0);
        tick();
        exp_head("end_fc", 32'hFC, 32'd63);
        chk("range_fault", 64'(fault_o), 64'd1);
        tick();
        exp_idle("range_idle");
        chk("range_fault_hold", 64'(fault_o), 64'd1);
`else
        redirect(32'h42);
        exp_idle("align_bubble");
        tick();
        exp_head("align", 32'h40, 32'd16);
        chk("align_fault", 64'(fault_o), 64'd0);
        redirect(32'hF8);
        exp_idle("wrap_bubble");
        tick();
        exp_head("wrap_f8", 32'hF8, 32'd62);
        tick();
        exp_head("wrap_fc", 32'hFC, 32'd63);
        tick();
        exp_head("wrap_100", 32'h100, 32'd0);
        chk("wrap_fault", 64'(fault_o), 64'd0);
        tick();
        exp_head("wrap_104", 32'h104, 32'd1);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
